// File: rtl/operand_stage.sv
// operand_stage: ID->EX pipeline register with operand forwarding,
// load-use hazard detection, bubble insertion and a saturating bubble counter.
module operand_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    // decode side
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_is_load,
    input  logic              id_regwrite,
    // feedback and pipeline control
    input  logic [31:0]       ex_alu_result,
    input  logic [4:0]        mem_rd,
    input  logic              mem_regwrite,
    input  logic [31:0]       mem_result,
    input  logic [4:0]        wb_rd,
    input  logic              wb_regwrite,
    input  logic [31:0]       wb_result,
    input  logic              flush,
    input  logic              ex_stall,
    // outputs
    output logic              stall_id,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs1val,
    output logic [31:0]       ex_rs2val,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_is_load,
    output logic              ex_regwrite,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Operand select: x0 is hard zero; youngest producer wins (EX, MEM, WB),
    // otherwise the register-file read data is used.
    function automatic logic [31:0] operand_sel(
        input logic [4:0]  rs,
        input logic        uses,
        input logic [31:0] rdata,
        input logic        ex_en,
        input logic [4:0]  ex_dst,
        input logic [31:0] ex_res,
        input logic        mem_en,
        input logic [4:0]  mem_dst,
        input logic [31:0] mem_res,
        input logic        wb_en,
        input logic [4:0]  wb_dst,
        input logic [31:0] wb_res
    );
        logic [31:0] val;
        if (rs == 5'd0) begin
            val = 32'h0000_0000;
        end else if (uses && ex_en && (ex_dst == rs)) begin
            val = ex_res;
        end else if (uses && mem_en && (mem_dst == rs)) begin
            val = mem_res;
        end else if (uses && wb_en && (wb_dst == rs)) begin
            val = wb_res;
        end else begin
            val = rdata;
        end
        return val;
    endfunction

    logic        ex_fwd_en_s;
    logic        load_use_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;

    // Hazard detection, stall request and forwarded operand values.
    always_comb begin
        ex_fwd_en_s = 1'b0;
        load_use_s  = 1'b0;
        stall_id    = 1'b0;
        // A load's result is not available in EX, so it never forwards from there.
        ex_fwd_en_s = ex_valid & ex_regwrite & ~ex_is_load;
        if (id_valid && ex_valid && ex_is_load && ex_regwrite && (ex_rd != 5'd0)) begin
            load_use_s = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd));
        end else begin
            load_use_s = 1'b0;
        end
        stall_id  = (load_use_s | ex_stall) & ~flush;
        rs1_val_s = operand_sel(id_rs1, id_uses_rs1, id_rdata1,
                                ex_fwd_en_s, ex_rd, ex_alu_result,
                                mem_regwrite, mem_rd, mem_result,
                                wb_regwrite, wb_rd, wb_result);
        rs2_val_s = operand_sel(id_rs2, id_uses_rs2, id_rdata2,
                                ex_fwd_en_s, ex_rd, ex_alu_result,
                                mem_regwrite, mem_rd, mem_result,
                                wb_regwrite, wb_rd, wb_result);
    end

    // EX pipeline register: flush > stall-hold > bubble > capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid    <= 1'b0;
            ex_pc       <= 32'h0000_0000;
            ex_rs1val   <= 32'h0000_0000;
            ex_rs2val   <= 32'h0000_0000;
            ex_imm      <= 32'h0000_0000;
            ex_rd       <= 5'd0;
            ex_ctrl     <= {CTRL_W{1'b0}};
            ex_is_load  <= 1'b0;
            ex_regwrite <= 1'b0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_regwrite <= 1'b0;
        end else if (ex_stall) begin
            ex_valid    <= ex_valid;
            ex_is_load  <= ex_is_load;
            ex_regwrite <= ex_regwrite;
        end else if (load_use_s) begin
            ex_valid    <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_regwrite <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1val   <= rs1_val_s;
            ex_rs2val   <= rs2_val_s;
            ex_imm      <= id_imm;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_ctrl;
            ex_is_load  <= id_is_load & id_valid;
            ex_regwrite <= id_regwrite & id_valid;
        end
    end

    // Saturating count of inserted load-use bubbles (stalls and flushes excluded).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubble_cnt <= {CNT_W{1'b0}};
        end else if (!flush && !ex_stall && load_use_s && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt <= bubble_cnt;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Directed, table-driven bench for operand_stage.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_is_load, id_regwrite;
    logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [15:0] id_ctrl;
    logic [31:0] ex_alu_result, mem_result, wb_result;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite, flush, ex_stall;
    logic        stall_id, ex_valid, ex_is_load, ex_regwrite;
    logic [31:0] ex_pc, ex_rs1val, ex_rs2val, ex_imm;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl, bubble_cnt;
    // small-counter instance for saturation
    logic        s_stall_id, s_ex_valid, s_ex_is_load, s_ex_regwrite;
    logic [31:0] s_ex_pc, s_ex_rs1val, s_ex_rs2val, s_ex_imm;
    logic [4:0]  s_ex_rd;
    logic [15:0] s_ex_ctrl;
    logic [1:0]  s_bubble_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    operand_stage dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_is_load(id_is_load), .id_regwrite(id_regwrite),
        .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_result(mem_result), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .wb_result(wb_result), .flush(flush), .ex_stall(ex_stall),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1val(ex_rs1val), .ex_rs2val(ex_rs2val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_is_load(ex_is_load),
        .ex_regwrite(ex_regwrite), .bubble_cnt(bubble_cnt)
    );

    operand_stage #(.CTRL_W(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_is_load(id_is_load), .id_regwrite(id_regwrite),
        .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_result(mem_result), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .wb_result(wb_result), .flush(flush), .ex_stall(ex_stall),
        .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
        .ex_rs1val(s_ex_rs1val), .ex_rs2val(s_ex_rs2val), .ex_imm(s_ex_imm),
        .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl), .ex_is_load(s_ex_is_load),
        .ex_regwrite(s_ex_regwrite), .bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        logic v; logic [4:0] rs1, rs2, rd; logic u1, u2; logic [31:0] d1, d2; logic ld, we;
        logic [31:0] alu; logic [4:0] mrd; logic mwe; logic [31:0] mres;
        logic [4:0] wrd; logic wwe; logic [31:0] wres;
        logic e_stall, e_valid, e_ld, e_we; logic [4:0] e_rd; logic [31:0] e_r1, e_r2;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic u1, input logic u2,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic ld, input logic we);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_rdata1 = d1; id_rdata2 = d2;
        id_is_load = ld; id_regwrite = we;
    endtask

    task automatic no_fwd();
        ex_alu_result = 32'h0; mem_rd = 5'd0; mem_regwrite = 1'b0; mem_result = 32'h0;
        wb_rd = 5'd0; wb_regwrite = 1'b0; wb_result = 32'h0;
    endtask

    initial begin
        // v rs1 rs2 rd u1 u2 d1 d2 ld we | alu mrd mwe mres wrd wwe wres | stall valid ld we rd r1 r2
        vecs[0] = '{1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'hA, 32'hB, 1'b0, 1'b1,
                    32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hA, 32'hB};
        vecs[1] = '{1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 32'h99, 32'h77, 1'b0, 1'b1,
                    32'h11, 5'd5, 1'b1, 32'h22, 5'd5, 1'b1, 32'h33,
                    1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h11, 32'h0};
        vecs[2] = '{1'b1, 5'd5, 5'd0, 5'd8, 1'b1, 1'b1, 32'h99, 32'h77, 1'b0, 1'b1,
                    32'h11, 5'd5, 1'b1, 32'h22, 5'd5, 1'b1, 32'h33,
                    1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h22, 32'h0};
        vecs[3] = '{1'b1, 5'd5, 5'd3, 5'd0, 1'b1, 1'b1, 32'h99, 32'h44, 1'b0, 1'b0,
                    32'h11, 5'd9, 1'b1, 32'h22, 5'd5, 1'b1, 32'h33,
                    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h33, 32'h44};
        vecs[4] = '{1'b1, 5'd5, 5'd0, 5'd11, 1'b1, 1'b1, 32'h55, 32'h77, 1'b0, 1'b1,
                    32'h11, 5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF,
                    1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 32'h55, 32'h0};
        vecs[5] = '{1'b0, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 32'h1, 32'h2, 1'b0, 1'b1,
                    32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 32'h1, 32'h2};
        vecs[6] = '{1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1,
                    32'h0, 5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 32'h66,
                    1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h66, 32'h66};
        vecs[7] = '{1'b0, 5'd7, 5'd2, 5'd13, 1'b1, 1'b1, 32'h70, 32'h2, 1'b0, 1'b1,
                    32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd13, 32'h70, 32'h2};
        vecs[8] = '{1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h3, 32'h4, 1'b1, 1'b1,
                    32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h3, 32'h4};
        vecs[9] = '{1'b1, 5'd7, 5'd3, 5'd9, 1'b0, 1'b1, 32'h10, 32'h20, 1'b0, 1'b1,
                    32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h10, 32'h20};

        rstn = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        id_pc = 32'h0; id_imm = 32'h0; id_ctrl = 16'h0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        no_fwd();
        #12;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_rs1", ex_rs1val, 32'h0);
        chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            drive_id(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
                     vecs[i].d1, vecs[i].d2, vecs[i].ld, vecs[i].we);
            id_pc = 32'h1000 + 32'(i) * 32'd4; id_imm = 32'(i) + 32'h100; id_ctrl = 16'(i) + 16'hC0;
            ex_alu_result = vecs[i].alu; mem_rd = vecs[i].mrd; mem_regwrite = vecs[i].mwe;
            mem_result = vecs[i].mres; wb_rd = vecs[i].wrd; wb_regwrite = vecs[i].wwe;
            wb_result = vecs[i].wres;
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, stall_id}, {31'd0, vecs[i].e_stall});
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_load", i), {31'd0, ex_is_load}, {31'd0, vecs[i].e_ld});
            chk($sformatf("v%0d_we", i), {31'd0, ex_regwrite}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_rs1", i), ex_rs1val, vecs[i].e_r1);
            chk($sformatf("v%0d_rs2", i), ex_rs2val, vecs[i].e_r2);
            chk($sformatf("v%0d_pc", i), ex_pc, 32'h1000 + 32'(i) * 32'd4);
            chk($sformatf("v%0d_imm", i), ex_imm, 32'(i) + 32'h100);
        end
        chk("cnt_after_table", {16'd0, bubble_cnt}, 32'd0);

        // load-use: load x7 then consumer of x7
        no_fwd();
        drive_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd7, 5'd0, 5'd10, 1'b1, 1'b0, 32'hBAD, 32'h0, 1'b0, 1'b1);
        #1;
        chk("lu_stall", {31'd0, stall_id}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_we", {31'd0, ex_regwrite}, 32'd0);
        chk("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
        chk("lu_stall_clear", {31'd0, stall_id}, 32'd0);
        mem_rd = 5'd7; mem_regwrite = 1'b1; mem_result = 32'h77;
        tick();
        chk("lu_enter_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_enter_rs1", ex_rs1val, 32'h77);
        chk("lu_enter_rd", {27'd0, ex_rd}, 32'd10);
        chk("lu_cnt_hold", {16'd0, bubble_cnt}, 32'd1);

        // downstream stall for three cycles
        no_fwd();
        ex_stall = 1'b1;
        drive_id(1'b1, 5'd3, 5'd4, 5'd20, 1'b1, 1'b1, 32'h1234, 32'h5678, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st%0d_stall", c), {31'd0, stall_id}, 32'd1);
            tick();
            chk($sformatf("st%0d_valid", c), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("st%0d_rs1", c), ex_rs1val, 32'h77);
            chk($sformatf("st%0d_rd", c), {27'd0, ex_rd}, 32'd10);
        end
        chk("st_cnt", {16'd0, bubble_cnt}, 32'd1);
        ex_stall = 1'b0;

        // flush beats stall and load-use
        drive_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd7, 5'd7, 5'd11, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
        ex_stall = 1'b1; flush = 1'b1;
        #1;
        chk("fl_stall_id", {31'd0, stall_id}, 32'd0);
        tick();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_we", {31'd0, ex_regwrite}, 32'd0);
        chk("fl_load", {31'd0, ex_is_load}, 32'd0);
        chk("fl_cnt", {16'd0, bubble_cnt}, 32'd1);
        ex_stall = 1'b0; flush = 1'b0;

        // repeated bubbles; 2-bit counter saturates at 3
        for (int b = 0; b < 4; b++) begin
            drive_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
            tick();
            drive_id(1'b1, 5'd0, 5'd7, 5'd12, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
            #1;
            chk($sformatf("sat%0d_stall", b), {31'd0, stall_id}, 32'd1);
            tick();
        end
        chk("sat_small_cnt", {30'd0, s_bubble_cnt}, 32'd3);
        chk("sat_main_cnt", {16'd0, bubble_cnt}, 32'd5);

        // async reset mid-stall
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'hAAAA, 32'hBBBB, 1'b0, 1'b1);
        tick();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        ex_stall = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_rs1", ex_rs1val, 32'h0);
        chk("arst_rd", {27'd0, ex_rd}, 32'd0);
        chk("arst_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("arst_small_cnt", {30'd0, s_bubble_cnt}, 32'd0);
        tick();
        chk("arst_hold", {31'd0, ex_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1; ex_stall = 1'b0;
        drive_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 32'h5678, 32'h9ABC, 1'b0, 1'b1);
        tick();
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_rs1", ex_rs1val, 32'h5678);
        chk("post_rst_rd", {27'd0, ex_rd}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, width of the opaque decoded-control bundle.
REQ-002 SHALL have parameter CNT_W, default 16, width of the load-use bubble counter.
REQ-003 SHALL have one clock and an asynchronous active-low reset:
- CLK  in  1  clock; all state updates on posedge.
- RSTN  in  1  asynchronous active-low reset.
REQ-004 SHALL have the decode-side inputs:
- ID_VALID  in  1  decode slot holds an instruction.
- ID_PC  in  32  instruction PC.
- ID_RS1, ID_RS2, ID_RD  in  5 each  register numbers.
- ID_USES_RS1, ID_USES_RS2  in  1 each  operand actually read.
- ID_RDATA1, ID_RDATA2  in  32 each  register-file read data, valid before posedge.
- ID_IMM  in  32  immediate.
- ID_CTRL  in  CTRL_W  control bundle.
- ID_IS_LOAD, ID_REGWRITE  in  1 each  load flag, writes rd.
REQ-005 SHALL have the feedback and pipeline-control inputs:
- EX_ALU_RESULT  in  32  combinational ALU result of the instruction now held in this stage's output register.
- MEM_RD  in  5, MEM_REGWRITE  in  1, MEM_RESULT  in  32  memory-stage writer.
- WB_RD  in  5, WB_REGWRITE  in  1, WB_RESULT  in  32  writeback-stage writer; same value and number drive the register-file write port.
- FLUSH  in  1  taken branch/jump; kill the instruction entering EX.
- EX_STALL  in  1  downstream busy; hold EX.
REQ-006 SHALL have the outputs:
- STALL_ID  out  1  hold fetch/decode this cycle.
- EX_VALID  out  1.
- EX_PC, EX_RS1VAL, EX_RS2VAL, EX_IMM  out  32 each.
- EX_RD  out  5.
- EX_CTRL  out  CTRL_W.
- EX_IS_LOAD, EX_REGWRITE  out  1 each.
- BUBBLE_CNT  out  CNT_W  number of load-use bubbles.

Function
REQ-007 SHALL register all EX_* outputs; latency ID to EX is exactly one cycle.
REQ-008 SHALL forward each used operand with rs != 0. Priority:
- EX slot: EX_VALID & EX_REGWRITE & !EX_IS_LOAD & EX_RD==rs, value EX_ALU_RESULT.
- then MEM_REGWRITE & MEM_RD==rs, value MEM_RESULT.
- then WB_REGWRITE & WB_RD==rs, value WB_RESULT.
- else ID_RDATAx.
REQ-009 SHALL capture an operand with rs == 0 as 32'h0000_0000, regardless of any forwarding match.
REQ-010 SHALL detect load-use when all of the following hold:
- ID_VALID;
- EX_VALID & EX_IS_LOAD & EX_REGWRITE & EX_RD != 0;
- (ID_USES_RS1 & ID_RS1==EX_RD) or (ID_USES_RS2 & ID_RS2==EX_RD).
REQ-011 SHALL, on load-use without FLUSH or EX_STALL, load a bubble: EX_VALID<=0, EX_REGWRITE<=0, EX_IS_LOAD<=0, other EX_* don't-care. The load then advances out of EX, so the hazard clears on the next cycle.
REQ-012 SHALL drive STALL_ID = (load_use | EX_STALL) & !FLUSH, combinationally.
REQ-013 SHALL apply next-state priority per posedge:
- FLUSH: EX_VALID<=0, EX_REGWRITE<=0, EX_IS_LOAD<=0, even if EX_STALL is asserted.
- else EX_STALL: hold all EX_* unchanged.
- else load_use: bubble per REQ-011.
- else capture the ID fields, with EX_VALID<=ID_VALID and EX_REGWRITE<=ID_REGWRITE&ID_VALID.
REQ-014 SHALL increment BUBBLE_CNT only when a REQ-011 bubble is inserted, saturating at all-ones with no wrap.
REQ-015 SHALL not count stall or flush cycles in BUBBLE_CNT.
REQ-016 SHALL ignore all operand fields when ID_VALID=0: no hazard and no STALL_ID contribution.

Reset
REQ-017 SHALL, while RSTN=0, asynchronously clear all EX_* outputs and BUBBLE_CNT to 0.
REQ-018 SHALL resume normal capture on the first posedge after RSTN rises.
REQ-019 SHALL drop any instruction in flight when reset is asserted mid-stall or mid-bubble.

Verification
REQ-020 Forward priority: EX slot ALU writes x5=0x11, MEM_RD=5 with 0x22, WB_RD=5 with 0x33, ID_RS1=5 -> EX_RS1VAL=0x11; remove the EX match -> 0x22; remove the MEM match -> 0x33.
REQ-021 x0: ID_RS2=0, MEM_RD=0, MEM_REGWRITE=1, MEM_RESULT=0xDEAD -> EX_RS2VAL=0.
REQ-022 Load-use: EX holds a load to x7, ID reads x7 -> STALL_ID=1 for one cycle, one bubble (EX_VALID=0), BUBBLE_CNT 0->1. Next cycle WB/MEM supplies the value and the instruction enters EX.
REQ-023 FLUSH with EX_STALL=1 and load_use=1 -> EX_VALID=0 next cycle, STALL_ID=0, BUBBLE_CNT unchanged.
REQ-024 EX_STALL=1 for 3 cycles -> EX_* stable and STALL_ID=1 throughout.
REQ-025 Preload BUBBLE_CNT=0xFFFF, force a bubble -> stays 0xFFFF. Assert RSTN=0 between clock edges -> outputs clear immediately.
